// File: rtl/gcd_sched_pkg.sv
// Shared types and defaults for the GCD request scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gcd_sched_pkg;

    localparam int STATE_W      = 2;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_W        = 32;
    localparam int DEF_MAX_ITER = 64;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_sub_core.sv
// Subtractive-Euclid datapath: x/y registers, one subtract step per cycle.
// Latency: load takes effect next cycle; done/result are combinational on x/y.
// Backpressure: none; the controller decides when to load and when to step.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, a, b      capture a new operand pair
//   step            perform one subtraction (larger minus smaller)
//   done            x==0 || y==0 || x==y
//   result          x|y, equal to the gcd once done is high
module gcd_sub_core
    import gcd_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result
);

    logic [W-1:0] x;
    logic [W-1:0] y;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= a;
            y <= b;
        end else if (step) begin
            // Magnitude compare first, so the subtraction never wraps.
            if (x > y) begin
                x <= x - y;
            end else begin
                y <= y - x;
            end
        end
    end

    assign done   = (x == '0) || (y == '0) || (x == y);
    // With one operand zero this yields the other; with x==y it yields x.
    assign result = x | y;

endmodule

// File: rtl/gcd_req_scheduler.sv
// Round-robin shares one iterative GCD engine among NREQ requesters, tagged result out.
// Latency: accept at T, rsp_valid at T+2+S (S subtract steps); limited to T+MAX_ITER+1 with GCD_ITER_LIMIT_EN.
// Backpressure: one operation in flight; no request is accepted until the result handshakes.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        per-requester handshake, at most one ready bit high
//   req_a, req_b               packed operands, slice i = [i*W +: W]
//   rsp_valid/rsp_ready        result handshake
//   rsp_data, rsp_id, rsp_err  gcd, originating requester, iteration-limit flag
//   busy                       high while an operation is running or awaiting handshake
// Build option: define GCD_ITER_LIMIT_EN to abort after MAX_ITER RUN cycles with rsp_err=1.
module gcd_req_scheduler
    import gcd_sched_pkg::*;
#(
    parameter  int NREQ     = DEF_NREQ,
    parameter  int W        = DEF_W,
    parameter  int MAX_ITER = DEF_MAX_ITER,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_err,
    output logic            busy
);

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   rsp_data_q;

    logic [IDW-1:0] grant;
    logic           grant_vld;
    logic           accept;
    logic           step;
    logic           finish;
    logic           err_fin;
    logic           core_done;
    logic [W-1:0]   core_result;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    int             idx;

    // First valid requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

    assign a_sel = req_a[int'(grant)*W +: W];
    assign b_sel = req_b[int'(grant)*W +: W];

    // Ready is suppressed while rst is high so nothing transfers during reset.
    assign accept    = (state_q == IDLE) && grant_vld && !rst;
    assign req_ready = accept ? (NREQ'(1) << grant) : '0;

`ifdef GCD_ITER_LIMIT_EN
    localparam int ITW = $clog2(MAX_ITER) + 1;
    logic [ITW-1:0] iter_cnt;
    logic           rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            iter_cnt <= '0;
        end else if (state_q == RUN) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (finish) begin
            rsp_err_q <= err_fin;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        finish  = 1'b0;
        err_fin = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
`ifdef GCD_ITER_LIMIT_EN
                else if (iter_cnt == ITW'(MAX_ITER - 1)) begin
                    finish  = 1'b1;
                    err_fin = 1'b1;
                    state_d = DONE;
                end
`endif
                else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= grant;
            end
            if (finish) begin
                rsp_data_q <= err_fin ? '0 : core_result;
            end
            if ((state_q == DONE) && rsp_ready) begin
                rr_ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    gcd_sub_core #(.W(W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (step),
        .a      (a_sel),
        .b      (b_sel),
        .done   (core_done),
        .result (core_result)
    );

    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_req_scheduler.sv
// Self-checking bench for gcd_req_scheduler: table vectors, hand sequences, random vs model.
// Latency: checks accept-to-rsp_valid cycle counts.
// Backpressure: exercises rsp_ready held low and simultaneous requesters.
module tb_gcd_req_scheduler;

    localparam int NREQ     = 4;
    localparam int W        = 32;
    localparam int MAX_ITER = 64;
`ifdef GCD_ITER_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_err;
    logic              busy;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_req_scheduler #(.NREQ(NREQ), .W(W), .MAX_ITER(MAX_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: Euclid with quotients, counting the subtractions the engine would do.
    task automatic model(input longint a, input longint b,
                         output longint d, output bit e, output int lat);
        longint x = a;
        longint y = b;
        longint s = 0;
        longint q;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) begin
                q = x / y;
                if (x % y == 0) begin s += q - 1; x = y; end
                else            begin s += q;     x = x % y; end
            end else begin
                q = y / x;
                if (y % x == 0) begin s += q - 1; y = x; end
                else            begin s += q;     y = y % x; end
            end
        end
        d = (x == 0) ? y : x;
        if (LIM && s >= MAX_ITER) begin
            d   = 0;
            e   = 1'b1;
            lat = MAX_ITER + 1;
        end else begin
            e   = 1'b0;
            lat = int'(s) + 2;
        end
    endtask

    // One lone request through to its response with rsp_ready high.
    task automatic do_one(input int id, input int unsigned a, input int unsigned b,
                          input longint exp_d, input bit exp_e, input int exp_lat,
                          input string nm);
        int t0;
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_accept_wait"}, n, 0);
        t0 = cyc;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, cyc - t0, exp_lat);
        check({nm, "_data"}, rsp_data, exp_d);
        check({nm, "_id"}, rsp_id, id);
        check({nm, "_err"}, rsp_err, exp_e);
        @(negedge clk);
        check({nm, "_valid_drop"}, rsp_valid, 0);
    endtask

    typedef struct {
        int          id;
        int unsigned a;
        int unsigned b;
        int unsigned d;
        bit          e;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        int seen;
        longint md;
        bit     me;
        int     ml;
        int unsigned ra;
        int unsigned rb;
        int     rid;

        tbl.push_back('{0, 48, 18, 6, 1'b0, 6});
        tbl.push_back('{2, 56, 98, 14, 1'b0, 6});
        tbl.push_back('{1, 101, 103, 1, 1'b0, 54});
        tbl.push_back('{3, 0, 0, 0, 1'b0, 2});
        tbl.push_back('{0, 0, 35, 35, 1'b0, 2});
        tbl.push_back('{1, 9, 0, 9, 1'b0, 2});
        if (LIM) tbl.push_back('{2, 1, 1000, 0, 1'b1, 65});
        else     tbl.push_back('{2, 1, 1000, 1, 1'b0, 1001});

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_busy", busy, 0);

        foreach (tbl[i]) begin
            do_one(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end

        // All four requesters valid straight out of reset: strict round-robin order.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 7 + i;
            req_b[i*W +: W] = 7 + i;
        end
        req_valid = '1;
        #1;
        check("rr_ready_in_reset", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NREQ; k++) begin
            n = 0;
            while (req_ready == 0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rr_grant%0d", k), req_ready, 1 << k);
            @(negedge clk);
            req_valid[k] = 1'b0;
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rr_id%0d", k), rsp_id, k);
            check($sformatf("rr_data%0d", k), rsp_data, 7 + k);
            @(negedge clk);
        end
        do_one(0, 7, 7, 7, 1'b0, 2, "rr_again0");

        // Reset in the middle of RUN: operation discarded, nothing emitted.
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[1*W +: W] = 101;
        req_b[1*W +: W] = 103;
        #1;
        check("mid_rst_accept", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        check("mid_rst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_data", rsp_data, 0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", seen, 0);
        do_one(0, 12, 8, 4, 1'b0, 4, "after_rst");

        // rsp_ready held low in DONE while another requester waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[1*W +: W] = 48;
        req_b[1*W +: W] = 18;
        req_a[3*W +: W] = 5;
        req_b[3*W +: W] = 5;
        #1;
        check("hold_accept", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1000;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_rise", rsp_valid, 1);
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            check($sformatf("hold_valid%0d", h), rsp_valid, 1);
            check($sformatf("hold_data%0d", h), rsp_data, 6);
            check($sformatf("hold_id%0d", h), rsp_id, 1);
            check($sformatf("hold_ready%0d", h), req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_next_grant", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_next_data", rsp_data, 5);
        check("hold_next_id", rsp_id, 3);
        @(negedge clk);

        // Random lone requests checked against the arithmetic model.
        for (int r = 0; r < 30; r++) begin
            rid = $urandom_range(0, NREQ - 1);
            ra  = (r % 5 == 0) ? 0 : $urandom_range(1, 200);
            rb  = $urandom_range(0, 200);
            model(ra, rb, md, me, ml);
            do_one(rid, ra, rb, md, me, ml, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
